// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_NINE    = 4'd9;

    // Bit counter must hold BIN_W-1, the number of shifts left after loading.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit.sv
// Double-dabble correction cell: a BCD digit above 4 gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
module bcd_dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Add-3-if-greater-than-4 adjustment.
    always_comb begin
        digit_out = (digit_in > 4'd4) ? (digit_in + 4'd3) : digit_in;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Produces DIGITS packed BCD digits, a sticky overflow flag and a leading-zero
// mask for display blanking; results are registered on entry to DONE.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter bit SATURATE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        overflow,
    output logic [DIGITS-1:0]           digit_en
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    bcd_state_e        state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_adj;
    logic [ACC_W-1:0]  acc_shifted;
    logic [ACC_W-1:0]  bcd_final;
    logic [BIN_W-1:0]  sr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_reg;
    logic              ovf_next;
    logic [DIGITS-1:0] digit_nz;
    logic [DIGITS-1:0] en_final;

    // One correction cell per accumulator digit; also flag non-zero digits of
    // the post-shift value for the leading-zero mask.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_dabble_digit u_digit (
                .digit_in  (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
            assign digit_nz[gi] = |acc_shifted[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
        end
    endgenerate

    // Next binary bit enters the LSD; the bit leaving the top digit is overflow.
    assign acc_shifted = {acc_adj[ACC_W-2:0], sr_reg[BIN_W-1]};
    assign ovf_next    = ovf_reg | acc_adj[ACC_W-1];

    // Final result and blanking mask, computed from the value after the last shift.
    always_comb begin
        logic any_hi;
        bcd_final = acc_shifted;
        en_final  = '0;
        any_hi    = 1'b0;
        if (SATURATE && ovf_next) begin
            for (int k = 0; k < DIGITS; k++) begin
                bcd_final[k*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
            end
            en_final = '1;
        end else begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
                any_hi      = any_hi | digit_nz[k];
                en_final[k] = any_hi;
            end
            en_final[0] = 1'b1;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            overflow  <= 1'b0;
            digit_en  <= DIGITS'(1);
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sr_reg    <= bin;
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(BIN_W - 1);
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_reg <= acc_shifted;
                    sr_reg  <= {sr_reg[BIN_W-2:0], 1'b0};
                    ovf_reg <= ovf_next;
                    if (cnt_reg == '0) begin
                        bcd       <= bcd_final;
                        overflow  <= ovf_next;
                        digit_en  <= en_final;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    // A request here starts the next conversion back-to-back.
                    if (start) begin
                        sr_reg    <= bin;
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= CNT_W'(BIN_W - 1);
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
